des_arbiter: RTL
================

# des_arbiter

Round-robin arbiter and sequencer that shares one `des_encryption` core among `N_REQ` requesters. It latches the selected requester's message and 16 round keys, pulses the core's start, and waits for done. It returns the result to the owning requester with a one-cycle response pulse, and flags a fault if the core does not answer within a watchdog window. It sits between the requester-side logic and the single DES datapath instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort. Must be ≥2 and greater than the worst-case core latency.
- `ID_W`, default `$clog2(N_REQ)`: width of `grant_id`.
- `clk`, in, 1: single clock, all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, N_REQ: one-cycle request pulse per requester.
- `req_message`, in, 64*N_REQ: requester i uses bits [64*i+63:64*i]. Bit 64*i+63 maps to core message bit 1.
- `req_round_keys`, in, 768*N_REQ: requester i uses bits [768*i+767:768*i]. MSB maps to core round_keys bit 1.
- `core_start`, out, 1: one-cycle start pulse to the core.
- `core_message`, out, 64: registered; stable from LAUNCH until the next grant.
- `core_round_keys`, out, 768: registered; same stability rule as `core_message`.
- `core_done`, in, 1: core completion; `core_result` is valid in the same cycle.
- `core_result`, in, 64: core ciphertext.
- `resp_valid`, out, N_REQ: one-hot, one-cycle pulse to the owning requester.
- `resp_result`, out, 64: registered; valid while `resp_valid` is high and held until the next response.
- `resp_error`, out, 1: high with `resp_valid` when the operation timed out.
- `busy`, out, 1: high in every state except IDLE.
- `grant_id`, out, ID_W: index of the requester currently or last served.

## Operation
- Reset values:
  - state IDLE; `pending`=0; `rr_ptr`=0; timeout counter 0.
  - All outputs 0: `core_start`, `core_message`, `core_round_keys`, `resp_valid`, `resp_result`, `resp_error`, `busy`, `grant_id`.
- Pending register: `pending[i]` is set on an edge where `req[i]`=1, and cleared on the edge that grants i.
  - If set and clear coincide for the same i, set wins, which queues a new request.
  - A repeated pulse while already pending is absorbed; no count is kept.
- Requester i must hold its operands stable from its `req` pulse until its `resp_valid` pulse. Operands are sampled on the grant edge.
- FSM states:
  - IDLE: if `pending`≠0, select the first set bit scanning from `rr_ptr` upward, wrapping at N_REQ. Latch that requester's operands into `core_message`/`core_round_keys`, set `grant_id`, clear its pending bit, go to LAUNCH. Otherwise stay.
  - LAUNCH: `core_start`=1 for exactly this cycle; clear the counter; go to WAIT.
  - WAIT: if `core_done`=1, register `core_result` into `resp_result`, clear `resp_error`, go to RESP. Otherwise increment the counter. When the counter reaches TIMEOUT-1, set `resp_result`=0 and `resp_error`=1, then go to RESP.
  - RESP: `resp_valid[grant_id]`=1; set `rr_ptr` to `grant_id`+1, wrapping N_REQ-1 to 0; go to IDLE.
- `core_done` is ignored outside WAIT, for example a stale done after reset or after a timeout.
- `core_start`, `resp_valid` and `busy` are decoded from the registered state, so they are glitch-free.
- Reset mid-operation: return to IDLE immediately, dropping all pending requests and the in-flight operation; no response is issued. The core's own reset is separate and is not driven by this block.

## Timing
- Idle arbiter, `req[i]` pulse sampled at edge E0:
  - E1: enter LAUNCH.
  - `core_start` is high between E1 and E2.
  - E2: enter WAIT.
- `core_done` sampled at edge Ed leads to RESP; `resp_valid[i]` is high between Ed and Ed+1; IDLE at Ed+1.
- Total latency from request to response is core latency + 3 cycles. Back-to-back service of another pending requester launches at Ed+2.
- Timeout: RESP is entered TIMEOUT cycles after entering WAIT.
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,N_REQ-1,0.

## Test plan
- Single request: requester 2 sends key schedule of 133457799BBCDFF1 with message 0123456789ABCDEF.
  - `resp_valid`=0100 and `resp_result`=85E813540F0AB405, `resp_error`=0.
  - `core_start` is exactly one cycle.
- Simultaneous `req`=1111 from reset: service order 0,1,2,3. Each `resp_result` matches that requester's Python-generated vector from `des_tests.txt`.
- Round-robin wrap: after serving 3, pulse `req`=1001 together → 0 is served before 3.
- Timeout: stub core never asserts done; 64 cycles after WAIT → `resp_valid` pulse, `resp_error`=1, `resp_result`=0. A later stray `core_done` is ignored.
- Re-request during own service: requester 1 pulses `req` while its operation is in WAIT → two responses, the second launched at Ed+2.
- Reset mid-WAIT: assert `rst` → all outputs 0 immediately; a core `done` arriving afterwards produces no `resp_valid`.

Source files
------------

// File: rtl/des_arbiter.sv
// des_arbiter: round-robin arbiter that time-shares one DES core among N_REQ requesters,
// with operand latching, a one-cycle response pulse and a watchdog timeout.
module des_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [64*N_REQ-1:0]    req_message,
    input  logic [768*N_REQ-1:0]   req_round_keys,
    output logic                   core_start,
    output logic [63:0]            core_message,
    output logic [767:0]           core_round_keys,
    input  logic                   core_done,
    input  logic [63:0]            core_result,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [63:0]            resp_result,
    output logic                   resp_error,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]    CMAX = CW'(TIMEOUT - 1);
    localparam logic [ID_W:0]    NR   = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE  = {{(N_REQ - 1){1'b0}}, 1'b1};

    state_t             state, state_next;
    logic [N_REQ-1:0]   pending, clr;
    logic [ID_W-1:0]    rr_ptr, sel;
    logic [ID_W:0]      sum, idx;
    logic               found, grant, timeout;
    logic [CW-1:0]      cnt;
    logic [63:0]        msg_arr [N_REQ];
    logic [767:0]       key_arr [N_REQ];

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_split
            assign msg_arr[g] = req_message[64*g +: 64];
            assign key_arr[g] = req_round_keys[768*g +: 768];
        end
    endgenerate

    // Scan downward in distance from rr_ptr so the closest pending requester wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            idx = sum >= NR ? sum - NR : sum;
            if (pending[idx[ID_W-1:0]]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        timeout    = cnt == CMAX;
        grant      = state == IDLE && found;
        clr        = grant ? ONE << sel : '0;
        state_next = state == IDLE   ? (found ? LAUNCH : IDLE) :
                     state == LAUNCH ? WAIT :
                     state == WAIT   ? ((core_done || timeout) ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pending         <= '0;
            rr_ptr          <= '0;
            cnt             <= '0;
            core_message    <= '0;
            core_round_keys <= '0;
            resp_result     <= '0;
            resp_error      <= 1'b0;
            grant_id        <= '0;
        end else begin
            state   <= state_next;
            pending <= (pending & ~clr) | req;
            cnt     <= state == WAIT ? cnt + 1'b1 : '0;
            if (grant) begin
                core_message    <= msg_arr[sel];
                core_round_keys <= key_arr[sel];
                grant_id        <= sel;
            end
            // A done in the final watchdog cycle still counts as a good result.
            if (state == WAIT && (core_done || timeout)) begin
                resp_result <= core_done ? core_result : '0;
                resp_error  <= !core_done;
            end
            if (state == RESP)
                rr_ptr <= grant_id == LAST ? '0 : grant_id + 1'b1;
        end
    end

    assign core_start = state == LAUNCH;
    assign busy       = state != IDLE;
    assign resp_valid = state == RESP ? ONE << grant_id : '0;
endmodule
